// File: rtl/wm_front_panel_if.sv
// wm_front_panel_if: board pins, controller status and panel outputs.
// The board/controller side uses the master modport; the panel uses slave.
interface wm_front_panel_if;
  logic       i_start_raw;
  logic       i_cancel_raw;
  logic       i_coin_raw;
  logic       i_lid_raw;
  logic [2:0] i_mode_raw;
  logic       i_ctl_idle;
  logic       i_ctl_ready;
  logic       i_ctl_soak;
  logic       i_ctl_done;
  logic       i_ctl_coinreturn;
  logic       o_start;
  logic       o_cancel;
  logic       o_coin_n;
  logic       o_lid;
  logic       o_mode_1;
  logic       o_mode_2;
  logic       o_mode_3;
  logic [3:0] o_credit;
  logic       o_refund;
  logic       o_refund_busy;

  modport master (
    output i_start_raw, i_cancel_raw, i_coin_raw, i_lid_raw, i_mode_raw,
    output i_ctl_idle, i_ctl_ready, i_ctl_soak, i_ctl_done, i_ctl_coinreturn,
    input  o_start, o_cancel, o_coin_n, o_lid, o_mode_1, o_mode_2, o_mode_3,
    input  o_credit, o_refund, o_refund_busy
  );

  modport slave (
    input  i_start_raw, i_cancel_raw, i_coin_raw, i_lid_raw, i_mode_raw,
    input  i_ctl_idle, i_ctl_ready, i_ctl_soak, i_ctl_done, i_ctl_coinreturn,
    output o_start, o_cancel, o_coin_n, o_lid, o_mode_1, o_mode_2, o_mode_3,
    output o_credit, o_refund, o_refund_busy
  );
endinterface

// File: rtl/wm_front_panel.sv
// wm_front_panel: synchronises and debounces the panel inputs, produces
// start/cancel pulses, holds the wash mode and manages coin credit/refunds.
// Build option: define WM_PANEL_DEBOUNCE_EN to include the debouncers;
// without it each debounced level is the synchroniser output (fast sim).
module wm_front_panel #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COIN_PRICE      = 2,
  parameter int REFUND_GAP      = 2500000
) (
  input logic            i_clk,
  input logic            i_rst_n,
  wm_front_panel_if.slave bus
);
  // Input vector order: start, cancel, coin, lid, mode[2:0]
  localparam int NUM_IN = 7;
  localparam logic [NUM_IN-1:0] RST_LEVEL = 7'b000_1_0_0_0; // lid resets open
  localparam int GAP_W = ($clog2(REFUND_GAP + 1) > 0) ? $clog2(REFUND_GAP + 1) : 1;

  typedef enum logic [1:0] {COLLECT, PAID, RUN, REFUND} state_t;

  logic [NUM_IN-1:0] raw;
  logic [NUM_IN-1:0] level;
  logic [2:0]        level_d;
  logic [2:0]        pulse;
  logic [2:0]        valid_mode;
  logic              coin_edge;

  state_t            state_reg, state_next;
  logic [3:0]        credit_reg;
  logic [GAP_W-1:0]  gap_reg;
  logic [2:0]        mode_hold;
  logic              coin_n, busy, refund_fire, fee_take, run_exit;
  logic [2:0]        mode_out;

  assign raw = {bus.i_mode_raw, bus.i_lid_raw, bus.i_coin_raw,
                bus.i_cancel_raw, bus.i_start_raw};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_in
      logic sync1, sync2;

      // two-flop synchroniser for the raw pin
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          sync1 <= RST_LEVEL[gi];
          sync2 <= RST_LEVEL[gi];
        end else begin
          sync1 <= raw[gi];
          sync2 <= sync1;
        end
      end

`ifdef WM_PANEL_DEBOUNCE_EN
      localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      logic [DB_W-1:0] cnt;
      logic            lvl;

      // flip the level after a long enough run of disagreeing samples
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          cnt <= '0;
          lvl <= RST_LEVEL[gi];
        end else if (sync2 == lvl) begin
          cnt <= '0;
        end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt <= '0;
          lvl <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      assign level[gi] = lvl;
`else
      assign level[gi] = sync2;
`endif
    end
  endgenerate

  // rising-edge detect on start, cancel and coin levels
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_d <= 3'b000;
      pulse   <= 3'b000;
    end else begin
      level_d <= level[2:0];
      pulse   <= level[2:0] & ~level_d;
    end
  end

  assign coin_edge = pulse[2];

  // only a single active switch selects a mode
  always_comb begin
    valid_mode = 3'b000;
    case (level[6:4])
      3'b001, 3'b010, 3'b100: valid_mode = level[6:4];
      default:                valid_mode = 3'b000;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= COLLECT;
    else          state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: begin
        if (pulse[1] && credit_reg != 4'd0)         state_next = REFUND;
        else if (credit_reg >= 4'(COIN_PRICE))      state_next = PAID;
      end
      PAID: begin
        if (bus.i_ctl_soak)                         state_next = RUN;
        else if (bus.i_ctl_coinreturn)              state_next = REFUND;
      end
      RUN: begin
        if (bus.i_ctl_done || bus.i_ctl_idle)       state_next = COLLECT;
      end
      REFUND: begin
        if (gap_reg == '0 && credit_reg == 4'd0)    state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // FSM outputs and per-state datapath strobes
  always_comb begin
    coin_n      = 1'b1;
    mode_out    = 3'b000;
    busy        = 1'b0;
    refund_fire = 1'b0;
    fee_take    = 1'b0;
    run_exit    = 1'b0;
    case (state_reg)
      PAID: begin
        coin_n   = 1'b0;
        mode_out = valid_mode;
        fee_take = bus.i_ctl_soak;
      end
      RUN: begin
        mode_out = mode_hold;
        run_exit = bus.i_ctl_done || bus.i_ctl_idle;
      end
      REFUND: begin
        busy        = 1'b1;
        refund_fire = (gap_reg == '0) && (credit_reg != 4'd0);
      end
      default: ;
    endcase
  end

  // credit: saturating coin add, fee deduction, refund decrement
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      credit_reg <= 4'd0;
    end else if (refund_fire) begin
      // a coin arriving with the refund simply replaces the dispensed one
      if (!coin_edge) credit_reg <= credit_reg - 4'd1;
    end else if (fee_take) begin
      credit_reg <= credit_reg + {3'b000, coin_edge && credit_reg != 4'hF}
                    - 4'(COIN_PRICE);
    end else if (coin_edge && credit_reg != 4'hF) begin
      credit_reg <= credit_reg + 4'd1;
    end
  end

  // idle spacing between refund pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               gap_reg <= '0;
    else if (state_reg != REFUND) gap_reg <= '0;
    else if (refund_fire)       gap_reg <= GAP_W'(REFUND_GAP);
    else if (gap_reg != '0)     gap_reg <= gap_reg - 1'b1;
  end

  // mode captured when the wash starts, cleared when it ends
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      mode_hold <= 3'b000;
    else if (fee_take) mode_hold <= valid_mode;
    else if (run_exit) mode_hold <= 3'b000;
  end

  assign bus.o_start       = pulse[0];
  assign bus.o_cancel      = pulse[1];
  assign bus.o_lid         = level[3];
  assign bus.o_coin_n      = coin_n;
  assign bus.o_mode_1      = mode_out[0];
  assign bus.o_mode_2      = mode_out[1];
  assign bus.o_mode_3      = mode_out[2];
  assign bus.o_credit      = credit_reg;
  assign bus.o_refund      = refund_fire;
  assign bus.o_refund_busy = busy;
endmodule

// File: tb/tb_wm_front_panel.sv
// tb_wm_front_panel: self-checking bench for wm_front_panel.
// Pulse outputs are checked through per-signal queues of expected cycles;
// level outputs through a table of vectors and hand-written sequences.
module tb_wm_front_panel;
  localparam int DB    = 4;
  localparam int PRICE = 2;
  localparam int GAP   = 3;
`ifdef WM_PANEL_DEBOUNCE_EN
  localparam int DBE = DB;
`else
  localparam int DBE = 0;
`endif
  localparam int PL   = DBE + 3;  // raw change -> pulse
  localparam int LVL  = DBE + 2;  // raw change -> level
  localparam int HOLD = DBE + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  int   q_start[$];
  int   q_cancel[$];
  int   q_refund[$];
  logic [3:0] q_lvl[$];

  typedef struct {
    logic [2:0] sw;
    logic       lid;
    logic [2:0] exp_mode;
    logic       exp_lid;
  } vec_t;
  vec_t vecs[8];

  wm_front_panel_if bus();

  wm_front_panel #(.DEBOUNCE_CYCLES(DB), .COIN_PRICE(PRICE), .REFUND_GAP(GAP)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  // pulse scoreboard: every observed pulse must match the next expected cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.o_start) begin
        if (q_start.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL start_pulse: got pulse at cycle %0d, required none", cyc);
        end else check("start_pulse_cycle", cyc, q_start.pop_front());
      end
      if (bus.o_cancel) begin
        if (q_cancel.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cancel_pulse: got pulse at cycle %0d, required none", cyc);
        end else check("cancel_pulse_cycle", cyc, q_cancel.pop_front());
      end
      if (bus.o_refund) begin
        if (q_refund.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL refund_pulse: got pulse at cycle %0d, required none", cyc);
        end else check("refund_pulse_cycle", cyc, q_refund.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_cyc(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  // one coin edge with exact credit and paid-flag timing
  task automatic coin(input int prev, input int exp, input bit n_pre, input bit n_post);
    int c;
    step(); c = cyc; bus.i_coin_raw = 1'b1;
    at_cyc(c + PL);
    check("credit_before_update", bus.o_credit, prev);
    at_cyc(c + PL + 1);
    check("credit_after_coin", bus.o_credit, exp);
    check("coin_n_at_credit", bus.o_coin_n, n_pre);
    at_cyc(c + PL + 2);
    check("coin_n_after_credit", bus.o_coin_n, n_post);
    step(); bus.i_coin_raw = 1'b0;
    at_cyc(cyc + HOLD);
  endtask

  task automatic press(input bit do_start, input bit do_cancel);
    int c;
    step(); c = cyc;
    if (do_start)  begin bus.i_start_raw  = 1'b1; q_start.push_back(c + PL);  end
    if (do_cancel) begin bus.i_cancel_raw = 1'b1; q_cancel.push_back(c + PL); end
    at_cyc(c + HOLD);
    step(); bus.i_start_raw = 1'b0; bus.i_cancel_raw = 1'b0;
    at_cyc(cyc + HOLD);
  endtask

  task automatic ctl_strobe(input int which);
    step();
    case (which)
      0: bus.i_ctl_soak = 1'b1;
      1: bus.i_ctl_done = 1'b1;
      default: bus.i_ctl_coinreturn = 1'b1;
    endcase
    step();
    bus.i_ctl_soak = 1'b0; bus.i_ctl_done = 1'b0; bus.i_ctl_coinreturn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int c0;
    logic [3:0] e;

    vecs[0] = '{sw: 3'b001, lid: 1'b0, exp_mode: 3'b001, exp_lid: 1'b0};
    vecs[1] = '{sw: 3'b010, lid: 1'b1, exp_mode: 3'b010, exp_lid: 1'b1};
    vecs[2] = '{sw: 3'b100, lid: 1'b0, exp_mode: 3'b100, exp_lid: 1'b0};
    vecs[3] = '{sw: 3'b011, lid: 1'b0, exp_mode: 3'b000, exp_lid: 1'b0};
    vecs[4] = '{sw: 3'b111, lid: 1'b1, exp_mode: 3'b000, exp_lid: 1'b1};
    vecs[5] = '{sw: 3'b000, lid: 1'b1, exp_mode: 3'b000, exp_lid: 1'b1};
    vecs[6] = '{sw: 3'b110, lid: 1'b0, exp_mode: 3'b000, exp_lid: 1'b0};
    vecs[7] = '{sw: 3'b010, lid: 1'b1, exp_mode: 3'b010, exp_lid: 1'b1};

    bus.i_start_raw = 1'b0; bus.i_cancel_raw = 1'b0; bus.i_coin_raw = 1'b0;
    bus.i_lid_raw = 1'b1;   bus.i_mode_raw = 3'b000;
    bus.i_ctl_idle = 1'b0;  bus.i_ctl_ready = 1'b0; bus.i_ctl_soak = 1'b0;
    bus.i_ctl_done = 1'b0;  bus.i_ctl_coinreturn = 1'b0;

    // reset values
    #23;
    check("rst_coin_n", bus.o_coin_n, 1);
    check("rst_lid", bus.o_lid, 1);
    check("rst_credit", bus.o_credit, 0);
    check("rst_start", bus.o_start, 0);
    check("rst_busy", bus.o_refund_busy, 0);
    check("rst_mode", {bus.o_mode_3, bus.o_mode_2, bus.o_mode_1}, 0);
    step(); rst_n = 1'b1; mon_en = 1'b1;
    at_cyc(cyc + HOLD);

    // start bounce 1-0-1-0 then stable high
    step(); c0 = cyc;
`ifdef WM_PANEL_DEBOUNCE_EN
    q_start.push_back(c0 + 4 + PL);
`else
    q_start.push_back(c0 + PL);
    q_start.push_back(c0 + 2 + PL);
    q_start.push_back(c0 + 4 + PL);
`endif
    bus.i_start_raw = 1'b1; step(); bus.i_start_raw = 1'b0; step();
    bus.i_start_raw = 1'b1; step(); bus.i_start_raw = 1'b0; step();
    bus.i_start_raw = 1'b1;
    at_cyc(c0 + 4 + 10);
    step(); bus.i_start_raw = 1'b0;
    at_cyc(cyc + HOLD);
    check("start_bounce_pending", q_start.size(), 0);

    // payment and run
    coin(0, 1, 1'b1, 1'b1);
    coin(1, 2, 1'b1, 1'b0);
    step(); c = cyc; bus.i_mode_raw = 3'b010;
    at_cyc(c + LVL + 1);
    check("paid_mode", {bus.o_mode_3, bus.o_mode_2, bus.o_mode_1}, 3'b010);
    ctl_strobe(0);
    at_cyc(cyc);
    check("run_credit", bus.o_credit, 0);
    check("run_coin_n", bus.o_coin_n, 1);
    step(); c = cyc; bus.i_mode_raw = 3'b100;
    at_cyc(c + LVL + 2);
    check("run_mode_frozen", {bus.o_mode_3, bus.o_mode_2, bus.o_mode_1}, 3'b010);
    press(1'b0, 1'b1);   // cancel during RUN forfeits the fee
    check("run_cancel_busy", bus.o_refund_busy, 0);
    check("run_cancel_mode", {bus.o_mode_3, bus.o_mode_2, bus.o_mode_1}, 3'b010);
    ctl_strobe(1);
    at_cyc(cyc);
    check("done_mode_clear", {bus.o_mode_3, bus.o_mode_2, bus.o_mode_1}, 3'b000);
    check("done_coin_n", bus.o_coin_n, 1);

    // mode / lid table in PAID
    coin(0, 1, 1'b1, 1'b1);
    coin(1, 2, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(); c = cyc;
      bus.i_mode_raw = vecs[i].sw; bus.i_lid_raw = vecs[i].lid;
      q_lvl.push_back({vecs[i].exp_lid, vecs[i].exp_mode});
      at_cyc(c + LVL);
      e = q_lvl.pop_front();
      check($sformatf("vec%0d_mode", i), {bus.o_mode_3, bus.o_mode_2, bus.o_mode_1}, e[2:0]);
      check($sformatf("vec%0d_lid", i), bus.o_lid, e[3]);
      at_cyc(c + LVL + 2);
    end

    // refund of 3 credits
    coin(2, 3, 1'b0, 1'b0);
    ctl_strobe(2);
    c = cyc - 1;   // coinreturn driven after edge c, sampled at edge c+1
    for (int k = 0; k < 3; k++) q_refund.push_back(c + 1 + 4 * k);
    for (int t = c + 1; t <= c + 13; t++) begin
      at_cyc(t);
      check("refund_busy", bus.o_refund_busy, 1);
    end
    check("refund_credit_end", bus.o_credit, 0);
    at_cyc(c + 14);
    check("refund_done_busy", bus.o_refund_busy, 0);
    check("refund_done_coin_n", bus.o_coin_n, 1);
    check("refund_pending", q_refund.size(), 0);

    // simultaneous start and cancel with no credit
    press(1'b1, 1'b1);
    check("start_cancel_busy", bus.o_refund_busy, 0);

    // saturation
    for (int k = 1; k <= 17; k++)
      coin((k - 1 > 15) ? 15 : k - 1, (k > 15) ? 15 : k, (k >= 3) ? 1'b0 : 1'b1,
           (k >= 2) ? 1'b0 : 1'b1);
    check("sat_credit", bus.o_credit, 15);

    // coin edge coincident with fee deduction at 15
    step(); c = cyc; bus.i_coin_raw = 1'b1;
    at_cyc(c + PL);
    check("fee_coin_pre_credit", bus.o_credit, 15);
    bus.i_ctl_soak = 1'b1;
    at_cyc(c + PL + 1);
    bus.i_ctl_soak = 1'b0;
    check("fee_coin_credit", bus.o_credit, 13);
    check("fee_coin_run", bus.o_coin_n, 1);
    step(); bus.i_coin_raw = 1'b0;
    at_cyc(cyc + HOLD);
    ctl_strobe(1);
    at_cyc(cyc + 1);
    check("repaid_coin_n", bus.o_coin_n, 0);

    // reset mid-refund
    ctl_strobe(2);
    c = cyc - 1;
    q_refund.push_back(c + 1);
    q_refund.push_back(c + 5);
    at_cyc(c + 7);
    check("mid_refund_credit", bus.o_credit, 11);
    check("mid_refund_busy", bus.o_refund_busy, 1);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_credit", bus.o_credit, 0);
    check("arst_busy", bus.o_refund_busy, 0);
    check("arst_coin_n", bus.o_coin_n, 1);
    check("arst_lid", bus.o_lid, 1);
    check("arst_refund", bus.o_refund, 0);
    check("arst_mode", {bus.o_mode_3, bus.o_mode_2, bus.o_mode_1}, 0);
    check("final_refund_pending", q_refund.size(), 0);
    check("final_start_pending", q_start.size(), 0);
    check("final_cancel_pending", q_cancel.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wm_front_panel.md
# wm_front_panel

Front-panel input conditioner and coin-credit manager feeding the washing-machine controller. It synchronises and debounces raw buttons, lid and mode switches, and produces single-cycle start/cancel pulses, a one-hot mode held stable for the whole wash, and the active-low "paid" coin level. It also watches controller status to deduct the fee when a cycle starts and to dispense refunds. It sits between the board I/O pins and the controller's `i_*` inputs.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles before a debounced level changes (10 ms at 50 MHz).
- `COIN_PRICE`, 2: credits consumed per wash, range 1..15.
- `REFUND_GAP`, 2500000: idle cycles after each refund pulse.
- `i_clk` in 1: system clock, 50 MHz.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_start_raw`, `i_cancel_raw`, `i_coin_raw` in 1 each: raw push-button / coin-sensor pins, active high.
- `i_lid_raw` in 1: raw lid switch, 1 = open.
- `i_mode_raw` in 3: raw mode switches; bit0 = mode 1.
- `i_ctl_idle`, `i_ctl_ready`, `i_ctl_soak`, `i_ctl_done`, `i_ctl_coinreturn` in 1 each: controller status.
- `o_start`, `o_cancel` out 1: one-cycle pulses to the controller.
- `o_coin_n` out 1: 0 = wash paid.
- `o_lid` out 1: debounced lid.
- `o_mode_1`, `o_mode_2`, `o_mode_3` out 1: one-hot mode or all zero.
- `o_credit` out 4: current credit, saturating.
- `o_refund` out 1: one-cycle coin-dispense pulse.
- `o_refund_busy` out 1: high in REFUND.

## Operation
- Every raw input uses a 2-FF synchroniser followed by a debouncer. The debounced level flips after the synced value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any agreeing sample clears the count.
- `o_start` and `o_cancel` fire on the rising edge of their debounced level. A coin rising edge is the credit event.
- Mode validity: exactly one debounced switch high gives that one-hot value; any other pattern gives 000.
- FSM states COLLECT, PAID, RUN, REFUND. Reset state is COLLECT.
  - COLLECT: `o_coin_n`=1. Go to PAID when credit ≥ `COIN_PRICE`. A cancel pulse with credit > 0 goes to REFUND.
  - PAID: `o_coin_n`=0; mode outputs track the validated switches. `i_ctl_soak`=1 goes to RUN: mode is frozen and credit −= `COIN_PRICE` on that edge. `i_ctl_coinreturn`=1 goes to REFUND.
  - RUN: `o_coin_n`=1; mode held. `i_ctl_done` or `i_ctl_idle` clears mode to 000 and goes to COLLECT. A cancel during RUN forfeits the fee.
  - REFUND: while credit > 0, pulse `o_refund` for 1 cycle, decrement credit, then wait `REFUND_GAP` cycles. At credit = 0, go to COLLECT.
- Credit arithmetic is 4-bit and saturates at 15; a coin at 15 is ignored.
  - A coin edge in the same cycle as the fee deduction gives credit + 1 − `COIN_PRICE`.
  - A coin edge in the same cycle as a refund decrement leaves credit unchanged.
  - Coins arriving during REFUND are refunded too.
- Simultaneous start and cancel pulses are both emitted; the controller gives cancel priority.

## Timing
- Reset values:
  - `o_coin_n`=1 and `o_lid`=1 (open, safe).
  - All other outputs 0, credit 0, all debounced levels 0 except lid = 1.
- Input-to-pulse latency: 2 (sync) + `DEBOUNCE_CYCLES` + 1 (edge) cycles from the first stable raw sample. `o_lid` and mode have the same latency, minus the edge stage.
- `o_coin_n` falls 1 cycle after credit reaches `COIN_PRICE`.
- `o_credit` is registered; it updates on the edge following the event.
- Asserting reset mid-refund discards the remaining credit immediately.

## Configuration
- `WM_PANEL_DEBOUNCE_EN` defined: debouncers present as described.
- Undefined: debounced level = synchroniser output, and `DEBOUNCE_CYCLES` is ignored. Latency becomes 3 cycles for pulses and 2 for levels. This is for fast simulation.

## Test plan
Bench settings: `DEBOUNCE_CYCLES`=4, `COIN_PRICE`=2, `REFUND_GAP`=3, macro defined.
- Start bounce: `i_start_raw` bounces 1-0-1-0 and then holds high for 10 cycles -> exactly one `o_start` pulse, 7 cycles after the stable high begins.
- Payment and run: two coin edges, mode switch 010, then the controller raises `i_ctl_soak`.
  - `o_credit` 1 then 2.
  - `o_coin_n` falls.
  - Mode = 010 and stays frozen when the switches change to 100.
  - Credit returns to 0 and `o_coin_n`=1.
- Refund: credit 3 in PAID, then `i_ctl_coinreturn` -> 3 `o_refund` pulses spaced 4 cycles apart, `o_refund_busy` high throughout, credit ends at 0, FSM in COLLECT.
- Saturation: 17 coin edges -> `o_credit`=15. An edge coincident with the fee deduction at credit 15 -> credit 13.
- Invalid mode: switches 011 in PAID -> mode outputs 000.
- Reset: reset asserted mid-REFUND -> all outputs at reset values asynchronously, credit 0.
